// File: rtl/btn_conditioner_if.sv
// Bundle of pad-side inputs and conditioned outputs of the button front end.
interface btn_conditioner_if #(
  parameter int NUM_BTN = 5
);
  logic               tick_en;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_long;

  modport master (
    output tick_en,
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  tick_en,
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );
endinterface

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: synchroniser, debounce, press/release
// one-shots, long-press and optional auto-repeat, all timed by a shared tick.
module btn_conditioner #(
  parameter int                 NUM_BTN      = 5,
  parameter int                 CNT_W        = 16,
  parameter int                 DEBOUNCE_CYC = 16,
  parameter int                 LONG_CYC     = 512,
  parameter int                 REPEAT_CYC   = 64,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK  = 5'b00110
) (
  input  logic             clk,
  input  logic             rst,
  btn_conditioner_if.slave bus
);

  localparam int MAX_CYC = (DEBOUNCE_CYC > LONG_CYC)
                         ? ((DEBOUNCE_CYC > REPEAT_CYC) ? DEBOUNCE_CYC : REPEAT_CYC)
                         : ((LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // A counter only ever reaches CYC-1 before being cleared, so $clog2(CYC) bits suffice.
  if (DEBOUNCE_CYC < 1 || LONG_CYC < 1 || REPEAT_CYC < 1 || $clog2(MAX_CYC) > CNT_W) begin : g_bad_cfg
    $error("btn_conditioner: timing parameters illegal or too large for CNT_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    REPEAT,
    HELD
  } state_t;

  logic [NUM_BTN-1:0]            sync1;
  logic [NUM_BTN-1:0]            sync2;
  logic [NUM_BTN-1:0]            stable;
  logic [NUM_BTN-1:0][CNT_W-1:0] dcnt;
  logic [NUM_BTN-1:0][CNT_W-1:0] hcnt;
  state_t [NUM_BTN-1:0]          state;
  logic [NUM_BTN-1:0]            press_q;
  logic [NUM_BTN-1:0]            release_q;
  logic [NUM_BTN-1:0]            long_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.btn_raw;
      sync2 <= sync1;
    end
  end

  // NOTE: the per-channel counters are flop banks, not a RAM, so they take the async reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      dcnt   <= '0;
    end else if (bus.tick_en) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] != stable[i]) begin
          if (dcnt[i] == DEB_LAST) begin
            stable[i] <= sync2[i];
            dcnt[i]   <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + CNT_ONE;
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  // Release is tested before any tick-driven event, so it wins a same-cycle collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      hcnt      <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i] <= IDLE;
      end
    end else begin
      // NOTE: pulses default low here; a later non-blocking write in this block overrides the default for that cycle.
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (state[i] == IDLE) begin
          if (stable[i]) begin
            state[i]   <= PRESSED;
            press_q[i] <= 1'b1;
            hcnt[i]    <= '0;
          end
        end else if (!stable[i]) begin
          state[i]     <= IDLE;
          release_q[i] <= 1'b1;
          hcnt[i]      <= '0;
        end else if (bus.tick_en) begin
          case (state[i])
            PRESSED: begin
              if (hcnt[i] == LONG_LAST) begin
                long_q[i] <= 1'b1;
                hcnt[i]   <= '0;
                state[i]  <= REPEAT_MASK[i] ? REPEAT : HELD;
              end else begin
                hcnt[i] <= hcnt[i] + CNT_ONE;
              end
            end
            REPEAT: begin
              if (hcnt[i] == REP_LAST) begin
                press_q[i] <= 1'b1;
                hcnt[i]    <= '0;
              end else begin
                hcnt[i] <= hcnt[i] + CNT_ONE;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign bus.btn_level   = stable;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_long    = long_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: timing-formula scoreboard per cycle,
// a vector table of pulse shapes, plus hand sequences for reset and tick gating.
module tb_btn_conditioner;

  localparam int         NB    = 5;
  localparam int         DEB   = 4;
  localparam int         LONG  = 10;
  localparam int         REP   = 3;
  localparam logic [4:0] RMASK = 5'b00110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btn_conditioner_if #(.NUM_BTN(NB)) bus ();

  btn_conditioner #(
    .NUM_BTN     (NB),
    .CNT_W       (16),
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC    (LONG),
    .REPEAT_CYC  (REP),
    .REPEAT_MASK (RMASK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef enum {EV_PRESS, EV_REL, EV_LONG, EV_UP, EV_DN} ev_kind_t;
  typedef struct {
    int       cyc;
    int       ch;
    ev_kind_t kind;
  } ev_t;
  typedef struct {
    logic [4:0] mask;
    int         glitch;
    int         len;
  } vec_t;

  ev_t        sb[$];
  vec_t       vecs[10];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  bit         sb_on = 1'b1;
  logic [4:0] exp_level = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input int ch, input ev_kind_t kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    sb.push_back(e);
  endtask

  // r = first edge that samples the raw high level, len = edges it stays high.
  task automatic expect_pulse(input int ch, input int r, input int len);
    int press_at;
    int dn_at;
    if (len < DEB) return;
    press_at = r + DEB + 2;
    dn_at    = r + len + DEB + 1;
    push(r + DEB + 1, ch, EV_UP);
    push(press_at, ch, EV_PRESS);
    push(dn_at, ch, EV_DN);
    push(dn_at + 1, ch, EV_REL);
    if (press_at + LONG <= dn_at) begin
      push(press_at + LONG, ch, EV_LONG);
      if (RMASK[ch]) begin
        for (int e = press_at + LONG + REP; e <= dn_at; e += REP) push(e, ch, EV_PRESS);
      end
    end
  endtask

  task automatic step();
    logic [4:0] ep;
    logic [4:0] er;
    logic [4:0] el;
    @(posedge clk);
    #1;
    cyc++;
    if (sb_on) begin
      ep = '0;
      er = '0;
      el = '0;
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].cyc == cyc) begin
          case (sb[k].kind)
            EV_PRESS: ep[sb[k].ch] = 1'b1;
            EV_REL:   er[sb[k].ch] = 1'b1;
            EV_LONG:  el[sb[k].ch] = 1'b1;
            EV_UP:    exp_level[sb[k].ch] = 1'b1;
            EV_DN:    exp_level[sb[k].ch] = 1'b0;
            default: ;
          endcase
          sb.delete(k);
        end
      end
      check("press", bus.btn_press, ep);
      check("release", bus.btn_release, er);
      check("long", bus.btn_long, el);
      check("level", bus.btn_level, exp_level);
    end
  endtask

  task automatic do_reset(input int n, input bit want_empty);
    if (want_empty) check("sb_drained", sb.size(), 0);
    sb.delete();
    rst = 1'b1;
    #1;
    exp_level = '0;
    check("rst_async_level", bus.btn_level, 0);
    check("rst_async_press", bus.btn_press, 0);
    check("rst_async_release", bus.btn_release, 0);
    check("rst_async_long", bus.btn_long, 0);
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic apply_pulse(input logic [4:0] mask, input int glitch, input int len);
    int r;
    if (glitch > 0) begin
      r = cyc + 1;
      for (int ch = 0; ch < NB; ch++) if (mask[ch]) expect_pulse(ch, r, glitch);
      bus.btn_raw = mask;
      repeat (glitch) step();
      bus.btn_raw = '0;
      step();
    end
    r = cyc + 1;
    for (int ch = 0; ch < NB; ch++) if (mask[ch]) expect_pulse(ch, r, len);
    bus.btn_raw = mask;
    repeat (len) step();
    bus.btn_raw = '0;
    repeat (14) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    int first;
    int npress;
    int nlong;
    int nfrz;
    logic [4:0] pv;

    vecs[0] = '{5'b00001, 0, 3};   // one tick short of debounce: rejected
    vecs[1] = '{5'b00001, 0, 4};   // exactly the debounce time: accepted
    vecs[2] = '{5'b00001, 3, 8};   // bounce then settle
    vecs[3] = '{5'b01000, 0, 10};  // release collides with long: release wins
    vecs[4] = '{5'b01000, 0, 11};  // shortest hold that fires long
    vecs[5] = '{5'b00001, 0, 36};  // long press, no repeat channel
    vecs[6] = '{5'b00010, 0, 31};  // auto-repeat on ch1
    vecs[7] = '{5'b11111, 0, 12};  // all channels together
    vecs[8] = '{5'b00100, 0, 20};  // last repeat lands one cycle before release
    vecs[9] = '{5'b00100, 0, 19};  // release collides with repeat: release wins

    bus.tick_en = 1'b1;
    bus.btn_raw = 5'b11111;
    do_reset(3, 1'b1);
    apply_pulse(5'b11111, 0, 8);

    for (int v = 0; v < 10; v++) begin
      do_reset(2, 1'b1);
      apply_pulse(vecs[v].mask, vecs[v].glitch, vecs[v].len);
    end

    // Tick gating: tick_en every 4th cycle, then frozen, then resumed.
    do_reset(2, 1'b1);
    sb_on  = 1'b0;
    first  = -1;
    npress = 0;
    nlong  = 0;
    nfrz   = 0;
    pv     = '0;
    bus.btn_raw = 5'b00100;
    for (int k = 1; k <= 40; k++) begin
      bus.tick_en = (k % 4 == 0);
      step();
      if (bus.btn_press != 0) begin
        npress++;
        if (first < 0) begin
          first = k;
          pv    = bus.btn_press;
        end
      end
      if (bus.btn_long != 0) nlong++;
    end
    check("gate_press_edge", first, 17);
    check("gate_press_chan", pv, 5'b00100);
    check("gate_press_count", npress, 1);
    check("gate_no_early_long", nlong, 0);
    bus.tick_en = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      if ((bus.btn_press | bus.btn_release | bus.btn_long) != 0) nfrz++;
    end
    check("gate_frozen_pulses", nfrz, 0);
    check("gate_frozen_level", bus.btn_level, 5'b00100);
    bus.tick_en = 1'b1;
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (bus.btn_long != 0 && first < 0) first = k;
    end
    check("gate_long_resume_edge", first, 4);
    sb_on = 1'b1;

    // Reset in the middle of auto-repeat on ch2 with the button still held.
    do_reset(2, 1'b0);
    bus.btn_raw = 5'b00100;
    r = cyc + 1;
    expect_pulse(2, r, 1000);
    repeat (30) step();
    do_reset(2, 1'b0);
    apply_pulse(5'b00100, 0, 20);

    check("sb_drained_final", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Parametrised, multi-channel push-button front end for the watch chip. It replaces the ad-hoc per-button edge logic feeding mode/set/inc/dec/light. Each channel provides synchronisation, debounce, one-shot press and release pulses, long-press detection, and optional auto-repeat while held, so inc/dec can scroll values. The block sits between the raw pad inputs and the watch control FSM. All channels share one timebase strobe.

Parameters:
NUM_BTN, 5, number of independent button channels
CNT_W, 16, width of every per-channel counter; must hold max(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC)
DEBOUNCE_CYC, 16, consecutive ticks a new level must persist before acceptance (>=1)
LONG_CYC, 512, ticks held in PRESSED before long-press fires (>=1)
REPEAT_CYC, 64, ticks between auto-repeat press pulses (>=1)
REPEAT_MASK, 5'b00110, per-channel auto-repeat enable (bit i = channel i)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
tick_en  in  1  timebase strobe; all counters advance only on cycles where tick_en=1
btn_raw  in  NUM_BTN  asynchronous raw button levels, 1=pressed
btn_level  out  NUM_BTN  debounced level per channel
btn_press  out  NUM_BTN  1-cycle pulse on accepted press and on each auto-repeat
btn_release  out  NUM_BTN  1-cycle pulse on accepted release
btn_long  out  NUM_BTN  1-cycle pulse when the long-press threshold is reached

Behaviour:
- Reset, asynchronous: synchronisers, stable levels, counters and pulse outputs go to 0, and every FSM goes to IDLE. Reset asserted mid-operation aborts any hold or repeat immediately. After release of reset, a button that is still held produces a fresh press only after the full debounce time.
- Synchroniser: 2 flops per channel. sync2 is the synchronised level.
- Debounce, per channel: on a tick with sync2 != stable:
  - if dcnt == DEBOUNCE_CYC-1, then stable <= sync2 and dcnt <= 0;
  - otherwise dcnt++.
  - Any tick with sync2 == stable clears dcnt. Glitches shorter than DEBOUNCE_CYC ticks are ignored.
- btn_level = stable (registered).
- Pulses are registered and appear the cycle after the stable edge.
  - With tick_en tied 1, btn_press goes high on the (DEBOUNCE_CYC+3)-th rising edge, counting the first edge that samples raw=1.
  - Release latency is symmetric.
- Per-channel FSM, with hcnt as the hold counter:
  - IDLE: stable rise -> PRESSED, btn_press=1, hcnt<=0.
  - PRESSED: each tick hcnt++. When hcnt reaches LONG_CYC-1 on a tick: btn_long=1, hcnt<=0, then go to REPEAT if REPEAT_MASK[i], else HELD.
  - REPEAT: each tick hcnt++. When hcnt reaches REPEAT_CYC-1 on a tick: btn_press=1, hcnt<=0. This repeats indefinitely.
  - HELD: no further pulses.
  - Any state, on stable fall: btn_release=1 and go to IDLE. A release on the same cycle as a long or repeat event takes precedence, so no long/repeat pulse is emitted in that cycle.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses.
- btn_press, btn_release and btn_long for a given channel are never high in the same cycle.
- Counters never wrap, because the compare-and-clear happens before overflow. A CNT_W too small for the parameters is a configuration error.
- tick_en=0 freezes all counters and FSM timing. Synchronisers keep sampling.

Test Plan:
Common setup: NUM_BTN=5, DEBOUNCE_CYC=4, LONG_CYC=10, REPEAT_CYC=3, REPEAT_MASK=5'b00110, tick_en=1.
1. Reset: hold rst 3 cycles with btn_raw=5'b11111 -> all outputs 0. After rst deasserts, btn_press=5'b11111 pulses for exactly 1 cycle on the 7th edge.
2. Bounce rejection: ch0 raw high for 3 cycles, low for 1, then high -> no press during the bounce. Exactly one press, 7 edges after the final rise. btn_level[0]=1.
3. Long press, no repeat: ch0 held 30 cycles -> press at edge 7, btn_long 10 cycles later, then no further pulses. On release: one btn_release, and btn_level[0]=0.
4. Auto-repeat: ch1 held 25 cycles after press -> btn_long at press+10, then btn_press at +13, +16, +19, ... until release. Then exactly one release and no stray press.
5. tick_en gating: tick_en pulsed every 4th cycle, ch2 pressed -> press appears after 4 ticks (~16 cycles). Holding tick_en=0 for 50 cycles produces no long pulse.
6. Reset mid-repeat: assert rst during REPEAT on ch2 -> outputs go to 0 immediately. After deassert with ch2 still held, a new press comes at edge 7, and btn_long again at press+10.
